// File: rtl/reset_handshake_ctrl.sv
// Source-domain initiator for a cross-domain reset: drives reset_out to the far
// domain, waits for its reset status to rise and fall, and reports done/busy/timeout.
module reset_handshake_ctrl #(
    parameter int MIN_ASSERT_CYCLES = 16,
    parameter int TIMEOUT_CYCLES    = 1024,
    parameter int SYNC_STAGES       = 2
) (
    input  logic clk0_in,
    input  logic reset_clk0,
    input  logic soft_reset_req,
    input  logic reset_ack_clk1,
    output logic reset_out,
    output logic busy,
    output logic reset_done,
    output logic timeout_err
);

    localparam int MAX_CYCLES = (MIN_ASSERT_CYCLES > TIMEOUT_CYCLES) ? MIN_ASSERT_CYCLES
                                                                     : TIMEOUT_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] ASSERT_LAST  = CNT_W'(MIN_ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE        = 2'd0;
    localparam logic [1:0] S_ASSERT      = 2'd1;
    localparam logic [1:0] S_WAIT_ACK_HI = 2'd2;
    localparam logic [1:0] S_RELEASE     = 2'd3;

    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   w_ack_s;
    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic                   w_timeout_hit;
    logic                   w_timeout_nxt;

    // NOTE: the synchronizer deliberately has no reset, so the far side's status
    // keeps being tracked straight through a local reset.
    always_ff @(posedge clk0_in) begin
        r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], reset_ack_clk1};
    end

    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

    // Ack beats timeout when both happen on the terminal count.
    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latch).
        w_state_nxt   = r_state;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (soft_reset_req) w_state_nxt = S_ASSERT;
            end
            S_ASSERT: begin
                if (r_cnt == ASSERT_LAST) w_state_nxt = S_WAIT_ACK_HI;
            end
            S_WAIT_ACK_HI: begin
                if (w_ack_s) begin
                    w_state_nxt = S_RELEASE;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_state_nxt   = S_RELEASE;
                    w_timeout_hit = 1'b1;
                end
            end
            S_RELEASE: begin
                if (!w_ack_s) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_state_nxt   = S_IDLE;
                    w_timeout_hit = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        w_timeout_nxt = timeout_err;
        if ((r_state == S_IDLE) && soft_reset_req) begin
            w_timeout_nxt = 1'b0;
        end else if (w_timeout_hit) begin
            w_timeout_nxt = 1'b1;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every flop sees
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk0_in) begin
        if (reset_clk0) begin
            r_state     <= S_ASSERT;
            r_cnt       <= '0;
            reset_out   <= 1'b1;
            busy        <= 1'b1;
            reset_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_state != S_IDLE) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            reset_out   <= (w_state_nxt == S_ASSERT) || (w_state_nxt == S_WAIT_ACK_HI);
            busy        <= (w_state_nxt != S_IDLE);
            reset_done  <= (w_state_nxt == S_IDLE) && !w_ack_s && !w_timeout_nxt;
            timeout_err <= w_timeout_nxt;
        end
    end

endmodule

// File: tb/tb_reset_handshake_ctrl.sv
// Bench for reset_handshake_ctrl: far domain modelled as a clk1 synchronizer loop
// (or a dead/stuck ack), outputs compared every cycle against a phase-level model.
`timescale 1ns/1ps
module tb_reset_handshake_ctrl;

    localparam int MIN_C = 16;
    localparam int TO_C  = 64;

    logic clk0_in        = 1'b0;
    logic clk1           = 1'b0;
    logic reset_clk0     = 1'b1;
    logic soft_reset_req = 1'b0;
    logic reset_ack_clk1 = 1'b0;
    logic reset_out;
    logic busy;
    logic reset_done;
    logic timeout_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ack_mode = 0;                 // 0 loopback, 1 dead far clock, 2 stuck high
    logic [1:0] far_sync = 2'b00;

    reset_handshake_ctrl #(
        .MIN_ASSERT_CYCLES(MIN_C),
        .TIMEOUT_CYCLES   (TO_C),
        .SYNC_STAGES      (2)
    ) dut (
        .clk0_in       (clk0_in),
        .reset_clk0    (reset_clk0),
        .soft_reset_req(soft_reset_req),
        .reset_ack_clk1(reset_ack_clk1),
        .reset_out     (reset_out),
        .busy          (busy),
        .reset_done    (reset_done),
        .timeout_err   (timeout_err)
    );

    // clk0 posedges at odd ns, clk1 posedges at even ns: the domains never collide.
    initial forever #5 clk0_in = ~clk0_in;
    initial begin
        #1;
        forever #7 clk1 = ~clk1;
    end

    always @(posedge clk1) begin
        far_sync <= {far_sync[0], reset_out};
        case (ack_mode)
            0:       reset_ack_clk1 <= far_sync[1];
            1:       reset_ack_clk1 <= 1'b0;
            default: reset_ack_clk1 <= 1'b1;
        endcase
    end

    // Reference model: phase plus time spent in it, stepped once per clk0 edge.
    typedef enum {PH_IDLE, PH_ASSERT, PH_WAIT, PH_RELEASE} phase_t;
    phase_t m_ph  = PH_IDLE;
    int     m_age = 0;
    bit     m_out, m_busy, m_done, m_terr;
    bit     m_s1, m_s2;
    bit     prev_out = 1'b0;
    int     rises = 0, rise_cyc = 0, fall_cyc = 0;

    task automatic model_edge(input bit rst, input bit req, input bit ack_raw);
        bit     ack_seen;
        phase_t nxt;
        ack_seen = m_s2;
        nxt      = m_ph;
        if (rst) begin
            nxt    = PH_ASSERT;
            m_terr = 1'b0;
            m_done = 1'b0;
            m_age  = 0;
        end else begin
            case (m_ph)
                PH_IDLE:    if (req) begin nxt = PH_ASSERT; m_terr = 1'b0; end
                PH_ASSERT:  if (m_age + 1 >= MIN_C) nxt = PH_WAIT;
                PH_WAIT:    if (ack_seen) nxt = PH_RELEASE;
                            else if (m_age + 1 >= TO_C) begin nxt = PH_RELEASE; m_terr = 1'b1; end
                PH_RELEASE: if (!ack_seen) nxt = PH_IDLE;
                            else if (m_age + 1 >= TO_C) begin nxt = PH_IDLE; m_terr = 1'b1; end
            endcase
            m_age  = (nxt == m_ph) ? m_age + 1 : 0;
            m_done = (nxt == PH_IDLE) && !ack_seen && !m_terr;
        end
        m_ph   = nxt;
        m_out  = (m_ph == PH_ASSERT) || (m_ph == PH_WAIT);
        m_busy = (m_ph != PH_IDLE);
        m_s2   = m_s1;
        m_s1   = ack_raw;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk0_in);
        model_edge(reset_clk0, soft_reset_req, reset_ack_clk1);
        cyc++;
        #2;
        chk("reset_out", reset_out, m_out);
        chk("busy", busy, m_busy);
        chk("reset_done", reset_done, m_done);
        chk("timeout_err", timeout_err, m_terr);
        if (reset_out && !prev_out) begin
            rises++;
            rise_cyc = cyc;
        end
        if (!reset_out && prev_out) fall_cyc = cyc;
        prev_out = reset_out;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk(tag, busy, 0);
    endtask

    task automatic soft_pulse(input int len);
        soft_reset_req = 1'b1;
        ticks(len);
        soft_reset_req = 1'b0;
    endtask

    initial begin
        int r0, rel_cnt, n;
        bit found;

        // Power-on: three reset cycles with the loopback far domain.
        tick();
        chk("por_reset_out", reset_out, 1);
        chk("por_busy", busy, 1);
        chk("por_done", reset_done, 0);
        chk("por_terr", timeout_err, 0);
        ticks(2);
        reset_clk0 = 1'b0;
        wait_idle("por_finish", 200);
        chk("por_hi_width_ge_min", (fall_cyc - 4) >= MIN_C, 1);
        tick();
        chk("por_done_after", reset_done, 1);
        chk("por_terr_after", timeout_err, 0);

        // Soft requests with random gaps and pulse lengths.
        for (int i = 0; i < 3; i++) begin
            ticks($urandom_range(1, 6));
            soft_pulse($urandom_range(1, 3));
            wait_idle("soft_finish", 200);
            chk("soft_width_ge_min", (fall_cyc - rise_cyc) >= MIN_C, 1);
            tick();
            chk("soft_done_after", reset_done, 1);
        end

        // Far side re-enters reset by itself while idle.
        ack_mode = 2;
        ticks($urandom_range(5, 9));
        chk("far_self_reset_done_low", reset_done, 0);
        ack_mode = 0;
        ticks(8);
        chk("far_self_reset_done_back", reset_done, 1);

        // Level request held high re-triggers on the first idle cycle.
        r0 = rises;
        soft_reset_req = 1'b1;
        tick();
        wait_idle("level_first", 200);
        tick();
        soft_reset_req = 1'b0;
        wait_idle("level_second", 200);
        chk("level_two_pulses", rises - r0, 2);

        // Dead far clock: WAIT_ACK_HI times out.
        ack_mode = 1;
        ticks(4);
        soft_pulse(1);
        wait_idle("dead_finish", MIN_C + 2 * TO_C + 20);
        chk("dead_fall_delay", fall_cyc - rise_cyc, MIN_C + TO_C);
        chk("dead_terr", timeout_err, 1);
        chk("dead_done", reset_done, 0);
        ack_mode = 0;
        ticks($urandom_range(2, 5));
        soft_pulse(1);
        chk("dead_terr_cleared", timeout_err, 0);
        wait_idle("dead_recover", 200);

        // Stuck ack: RELEASE times out after TO_C cycles.
        ack_mode = 2;
        ticks(6);
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        rel_cnt = 0;
        n = 0;
        while (busy && n < MIN_C + 2 * TO_C + 20) begin
            tick();
            if (busy && !reset_out) rel_cnt++;
            n++;
        end
        chk("stuck_finish", busy, 0);
        chk("stuck_release_cycles", rel_cnt, TO_C);
        chk("stuck_terr", timeout_err, 1);
        chk("stuck_done", reset_done, 0);
        ack_mode = 0;
        ticks(8);
        soft_pulse(1);
        wait_idle("stuck_recover", 200);
        tick();
        chk("stuck_recover_done", reset_done, 1);

        // Requests while busy are ignored.
        r0 = rises;
        soft_pulse(1);
        ticks($urandom_range(2, 12));
        soft_pulse(1);
        while (reset_out && (cyc - rise_cyc) < MIN_C + 1) tick();
        soft_pulse($urandom_range(1, 2));
        wait_idle("busy_req_finish", 200);
        chk("busy_req_one_pulse", rises - r0, 1);

        // Reset (with a simultaneous request) during RELEASE.
        ticks($urandom_range(1, 4));
        soft_pulse(1);
        found = 1'b0;
        n = 0;
        while (!found && n < 200) begin
            tick();
            if (busy && !reset_out && !reset_ack_clk1) found = 1'b1;
            n++;
        end
        chk("midrst_window", found, 1);
        reset_clk0     = 1'b1;
        soft_reset_req = 1'b1;
        tick();
        reset_clk0     = 1'b0;
        soft_reset_req = 1'b0;
        chk("midrst_reset_out", reset_out, 1);
        chk("midrst_busy", busy, 1);
        n = 0;
        while (!reset_ack_clk1 && n < 40) begin
            tick();
            n++;
        end
        chk("midrst_ack_rises", reset_ack_clk1, 1);
        wait_idle("midrst_finish", 200);
        chk("midrst_width_ge_min", (fall_cyc - rise_cyc) >= MIN_C, 1);
        tick();
        chk("midrst_done", reset_done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reset_handshake_ctrl.md
Name: reset_handshake_ctrl

Overview:
- Source-side (clk0) initiator for a cross-domain reset.
- Drives a reset request into a far clock domain, where it is synchronized into clk1 reset.
- Watches the far domain's reset status returned asynchronously, and only reports completion once the far side has both entered and left reset.
- Provides a minimum assert width, timeout detection and a clean done/busy status for clk0 control logic.

Parameters:
- MIN_ASSERT_CYCLES, 16: minimum clk0 cycles reset_out stays high per sequence; must be >= 1.
- TIMEOUT_CYCLES, 1024: maximum clk0 cycles spent waiting in each ack phase; must be >= 2.
- SYNC_STAGES, 2: flop stages on reset_ack_clk1; must be >= 2.

Ports:
- clk0_in  input  1  source-domain clock.
- reset_clk0  input  1  source-domain reset; synchronous to clk0_in, active-high.
- soft_reset_req  input  1  one-cycle (or level) request to run a far-side reset sequence.
- reset_ack_clk1  input  1  far-domain reset status (high while far side in reset); asynchronous to clk0_in.
- reset_out  output  1  registered reset request to far domain.
- busy  output  1  high while a sequence is in progress.
- reset_done  output  1  high when idle, far side out of reset, no error.
- timeout_err  output  1  sticky; a handshake phase timed out.

Behaviour:
- Clock and reset:
  - One clock, clk0_in.
  - reset_clk0 is synchronous and active-high.
  - All outputs are registered; initial values match the reset values.
- Ack input synchronizer:
  - reset_ack_clk1 passes through SYNC_STAGES flops; ack_s is the last stage.
  - The synchronizer flops are not cleared by reset_clk0.
- State machine states: IDLE, ASSERT, WAIT_ACK_HI, RELEASE.
- One counter, cnt, of width clog2(max(MIN_ASSERT_CYCLES, TIMEOUT_CYCLES)) + 1. It clears on every state entry.
- Reset (reset_clk0 = 1):
  - Next edge: state = ASSERT, cnt = 0, reset_out = 1, busy = 1, reset_done = 0, timeout_err = 0.
  - A local reset therefore always propagates to the far side.
  - Reset asserted mid-sequence restarts from ASSERT.
- IDLE:
  - reset_out = 0, busy = 0.
  - soft_reset_req = 1 -> ASSERT. reset_out = 1 and busy = 1 on the next edge (latency 1).
  - timeout_err clears on that same edge.
- ASSERT:
  - reset_out held at 1.
  - Leaves when cnt == MIN_ASSERT_CYCLES-1 -> WAIT_ACK_HI.
  - Result: exactly MIN_ASSERT_CYCLES cycles of reset_out = 1 in ASSERT.
- WAIT_ACK_HI:
  - reset_out held at 1.
  - ack_s = 1 -> RELEASE; reset_out = 0 on the next edge.
  - cnt == TIMEOUT_CYCLES-1 with ack_s = 0 -> timeout_err = 1, go to RELEASE anyway. This covers a dead far clock.
- RELEASE:
  - reset_out = 0.
  - ack_s = 0 -> IDLE.
  - cnt == TIMEOUT_CYCLES-1 with ack_s = 1 -> timeout_err = 1, go to IDLE.
- reset_done:
  - Registered as (next state == IDLE) && !ack_s && !timeout_err.
  - If the far side re-enters reset on its own while IDLE (ack_s rises), reset_done drops to 0 after 1 cycle and recovers when ack_s falls.
- soft_reset_req handling:
  - Ignored while busy; requests are not queued.
  - A level held high re-triggers on the first IDLE cycle.
- Simultaneous reset_clk0 and soft_reset_req: reset wins; result is identical.
- Timeout priority: when ack arrives on the exact timeout cycle, the ack wins and timeout_err is not set.
- Counter never wraps: it stops advancing at its terminal value because the state always changes there.

Test Plan:
- Power-on: reset_clk0 = 1 for 3 cycles, then 0; ack loopback through a 2-flop clk1 synchronizer with clk1 = 0.7*clk0 -> reset_out high for >= 16 cycles after reset release; busy = 1 until ack_s falls; then reset_done = 1, timeout_err = 0.
- Soft request: from IDLE, soft_reset_req pulse at cycle N -> reset_out = 1 and busy = 1 at N+1; reset_out stays 1 for at least 16 cycles; reset_done = 0 throughout; reset_done = 1 one cycle after ack_s returns to 0.
- Dead far clock: reset_ack_clk1 tied 0, TIMEOUT_CYCLES = 64, soft request -> reset_out falls exactly 16+64 cycles after entering ASSERT; timeout_err = 1; reset_done = 0; busy = 0. A next request clears timeout_err.
- Stuck ack: reset_ack_clk1 tied 1 -> passes WAIT_ACK_HI, spends 64 cycles in RELEASE, then timeout_err = 1, busy = 0, reset_done = 0.
- Request while busy: second soft_reset_req during ASSERT and WAIT_ACK_HI -> ignored; exactly one reset_out pulse is observed.
- Reset mid-sequence: reset_clk0 pulsed during RELEASE (reset_out = 0) -> reset_out = 1 on the next edge; the full 16-cycle ASSERT restarts; far-domain ack observed rising again.
